xor_mismatch_monitor: RTL and testbench

XOR_MISMATCH_MONITOR -- requirements
Module: xor_mismatch_monitor

---
 rtl/xor_mismatch_monitor_if.sv | 25 ++
 rtl/xor_mismatch_monitor.sv | 117 +++++++++++
 tb/tb_xor_mismatch_monitor.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/xor_mismatch_monitor_if.sv
// Bundles the monitored pair, clear requests and status outputs of the mismatch monitor.
// Signals: in1/in2/fault_clr/cnt_clr driven by master; out/suspect/fault/event_cnt driven by slave.
// master = environment driving the monitored signals, slave = the monitor itself.
interface xor_mismatch_monitor_if #(
   parameter int CNT_W = 8
);
   logic             in1;
   logic             in2;
   logic             fault_clr;
   logic             cnt_clr;
   logic             out;
   logic             suspect;
   logic             fault;
   logic [CNT_W-1:0] event_cnt;

   modport master (
      output in1, in2, fault_clr, cnt_clr,
      input  out, suspect, fault, event_cnt
   );

   modport slave (
      input  in1, in2, fault_clr, cnt_clr,
      output out, suspect, fault, event_cnt
   );
endinterface

// File: rtl/xor_mismatch_monitor.sv
// Debounced mismatch monitor for two redundant copies of a signal (OK/SUSPECT/FAIL FSM).
// Latency: out, suspect, fault, event_cnt are all registered, one cycle after the sampling edge.
// No backpressure: samples every edge. Ports: clk, rstn (async active-low), mon (slave modport).
module xor_mismatch_monitor #(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   xor_mismatch_monitor_if.slave mon
);

   // Run counter must hold values up to DEBOUNCE-1; keep at least one bit.
   localparam int               RUN_W   = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAIL    = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [RUN_W-1:0] run;
   logic [RUN_W-1:0] run_nxt;
   logic [RUN_W-1:0] run_inc;
   logic             mis;
   logic             enter_fail;

   logic             out_q;
   logic             suspect_q;
   logic             fault_q;
   logic [CNT_W-1:0] cnt_q;

   assign mis     = mon.in1 ^ mon.in2;
   assign run_inc = run + RUN_W'(1);

   // State and run counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_OK;
         run   <= '0;
      end else begin
         state <= state_nxt;
         run   <= run_nxt;
      end
   end

   // Next-state logic. fault_clr has priority in every state; in FAIL it also
   // masks the mismatch sampled on the same edge.
   always_comb begin
      state_nxt = state;
      run_nxt   = '0;
      if (mon.fault_clr) begin
         state_nxt = ST_OK;
      end else begin
         unique case (state)
            ST_OK: begin
               if (mis) begin
                  if (DEBOUNCE == 1) begin
                     state_nxt = ST_FAIL;
                  end else begin
                     state_nxt = ST_SUSPECT;
                     run_nxt   = RUN_W'(1);
                  end
               end
            end
            ST_SUSPECT: begin
               if (!mis) begin
                  state_nxt = ST_OK;
               end else if (run_inc == RUN_LIM) begin
                  state_nxt = ST_FAIL;
               end else begin
                  run_nxt = run_inc;
               end
            end
            ST_FAIL: begin
               state_nxt = ST_FAIL;
            end
            default: begin
               state_nxt = ST_OK;
            end
         endcase
      end
   end

   assign enter_fail = (state_nxt == ST_FAIL) && (state != ST_FAIL);

   // Registered outputs: decoding state_nxt into a flop gives a Moore output
   // that always equals the decode of the current state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q     <= 1'b0;
         suspect_q <= 1'b0;
         fault_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         out_q     <= mis;
         suspect_q <= (state_nxt == ST_SUSPECT);
         fault_q   <= (state_nxt == ST_FAIL);
         // A clear coinciding with a FAIL entry still records that entry.
         if (mon.cnt_clr) begin
            cnt_q <= enter_fail ? CNT_W'(1) : '0;
         end else if (enter_fail && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign mon.out       = out_q;
   assign mon.suspect   = suspect_q;
   assign mon.fault     = fault_q;
   assign mon.event_cnt = cnt_q;

endmodule

// File: tb/tb_xor_mismatch_monitor.sv
// Directed bench for xor_mismatch_monitor: three instances (default, CNT_W=2, DEBOUNCE=1).
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Summary line reports number of comparisons and failures.
module tb_xor_mismatch_monitor;

   logic clk;
   logic rstn;
   int   tests;
   int   failed;

   xor_mismatch_monitor_if #(.CNT_W(8)) ifa ();
   xor_mismatch_monitor_if #(.CNT_W(2)) ifb ();
   xor_mismatch_monitor_if #(.CNT_W(8)) ifc ();

   xor_mismatch_monitor #(.DEBOUNCE(3), .CNT_W(8)) dut_a (.clk(clk), .rstn(rstn), .mon(ifa));
   xor_mismatch_monitor #(.DEBOUNCE(3), .CNT_W(2)) dut_b (.clk(clk), .rstn(rstn), .mon(ifb));
   xor_mismatch_monitor #(.DEBOUNCE(1), .CNT_W(8)) dut_c (.clk(clk), .rstn(rstn), .mon(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin : stim
      int exp_cnt [5];
      exp_cnt = '{1, 2, 3, 3, 3};
      tests  = 0;
      failed = 0;

      ifa.in1 = 1'b0; ifa.in2 = 1'b0; ifa.fault_clr = 1'b0; ifa.cnt_clr = 1'b0;
      ifb.in1 = 1'b0; ifb.in2 = 1'b0; ifb.fault_clr = 1'b0; ifb.cnt_clr = 1'b0;
      ifc.in1 = 1'b0; ifc.in2 = 1'b0; ifc.fault_clr = 1'b0; ifc.cnt_clr = 1'b0;

      // Reset asserted before any clock edge: outputs must clear asynchronously.
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1;
      check("rst_out",     32'(ifa.out),       0);
      check("rst_suspect", 32'(ifa.suspect),   0);
      check("rst_fault",   32'(ifa.fault),     0);
      check("rst_cnt",     32'(ifa.event_cnt), 0);
      step();
      step();
      rstn = 1'b1;

      // Three consecutive mismatches on the default instance.
      ifa.in1 = 1'b1;
      step();
      check("m1_out",     32'(ifa.out),     1);
      check("m1_suspect", 32'(ifa.suspect), 1);
      check("m1_fault",   32'(ifa.fault),   0);
      step();
      check("m2_suspect", 32'(ifa.suspect), 1);
      check("m2_fault",   32'(ifa.fault),   0);
      step();
      check("m3_fault",   32'(ifa.fault),     1);
      check("m3_suspect", 32'(ifa.suspect),   0);
      check("m3_cnt",     32'(ifa.event_cnt), 1);

      // FAIL holds through matching inputs until fault_clr.
      ifa.in1 = 1'b0;
      repeat (10) step();
      check("hold_out",   32'(ifa.out),       0);
      check("hold_fault", 32'(ifa.fault),     1);
      check("hold_cnt",   32'(ifa.event_cnt), 1);
      ifa.in1 = 1'b1;          // mismatch on the clear edge is ignored
      ifa.fault_clr = 1'b1;
      step();
      ifa.fault_clr = 1'b0;
      ifa.in1 = 1'b0;
      check("clr_fault",   32'(ifa.fault),     0);
      check("clr_suspect", 32'(ifa.suspect),   0);
      check("clr_cnt",     32'(ifa.event_cnt), 1);
      step();
      check("ok_suspect",  32'(ifa.suspect),   0);

      // fault_clr in SUSPECT restarts the debounce count.
      ifa.in1 = 1'b1;
      step();
      step();
      check("s2_suspect", 32'(ifa.suspect), 1);
      ifa.fault_clr = 1'b1;
      step();
      ifa.fault_clr = 1'b0;
      check("sclr_suspect", 32'(ifa.suspect), 0);
      step();
      step();
      check("srst_suspect", 32'(ifa.suspect), 1);
      check("srst_fault",   32'(ifa.fault),   0);
      ifa.in1 = 1'b0;
      step();

      // cnt_clr zeroes the counter.
      ifa.cnt_clr = 1'b1;
      step();
      ifa.cnt_clr = 1'b0;
      check("cntclr_cnt", 32'(ifa.event_cnt), 0);

      // Mismatch x2, match, mismatch x2: never faults.
      ifa.in1 = 1'b1;
      step();
      step();
      ifa.in1 = 1'b0;
      step();
      check("gap_suspect", 32'(ifa.suspect), 0);
      ifa.in1 = 1'b1;
      step();
      step();
      check("gap_fault",   32'(ifa.fault),     0);
      check("gap_suspect2", 32'(ifa.suspect),  1);
      check("gap_cnt",     32'(ifa.event_cnt), 0);
      ifa.in1 = 1'b0;
      step();

      // Saturating counter on the CNT_W=2 instance.
      for (int i = 0; i < 5; i++) begin
         ifb.in2 = 1'b1;
         step();
         step();
         step();
         check("sat_fault", 32'(ifb.fault),     1);
         check("sat_cnt",   32'(ifb.event_cnt), 32'(exp_cnt[i]));
         ifb.in2 = 1'b0;
         ifb.fault_clr = 1'b1;
         step();
         ifb.fault_clr = 1'b0;
      end
      // cnt_clr on the same edge as a FAIL entry leaves one event.
      ifb.in2 = 1'b1;
      step();
      step();
      ifb.cnt_clr = 1'b1;
      step();
      ifb.cnt_clr = 1'b0;
      check("clrent_fault", 32'(ifb.fault),     1);
      check("clrent_cnt",   32'(ifb.event_cnt), 1);
      ifb.in2 = 1'b0;
      ifb.fault_clr = 1'b1;
      step();
      ifb.fault_clr = 1'b0;

      // DEBOUNCE=1: direct OK -> FAIL.
      ifc.in1 = 1'b1;
      step();
      check("d1_fault",   32'(ifc.fault),     1);
      check("d1_suspect", 32'(ifc.suspect),   0);
      check("d1_cnt",     32'(ifc.event_cnt), 1);
      ifc.in1 = 1'b0;
      ifc.fault_clr = 1'b1;
      step();
      ifc.fault_clr = 1'b0;
      check("d1_clr", 32'(ifc.fault), 0);

      // Build fault=1, event_cnt=2 on the default instance, then reset mid-cycle.
      ifa.in1 = 1'b1;
      step(); step(); step();
      ifa.in1 = 1'b0;
      ifa.fault_clr = 1'b1;
      step();
      ifa.fault_clr = 1'b0;
      ifa.in1 = 1'b1;
      step(); step(); step();
      check("pre_fault", 32'(ifa.fault),     1);
      check("pre_cnt",   32'(ifa.event_cnt), 2);
      #2 rstn = 1'b0;
      #1;
      check("mid_out",     32'(ifa.out),       0);
      check("mid_suspect", 32'(ifa.suspect),   0);
      check("mid_fault",   32'(ifa.fault),     0);
      check("mid_cnt",     32'(ifa.event_cnt), 0);
      step();
      step();
      rstn = 1'b1;
      step();
      step();
      check("post_fault",   32'(ifa.fault),   0);
      check("post_suspect", 32'(ifa.suspect), 1);
      step();
      check("post_fault3",  32'(ifa.fault),   1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
